// File: rtl/coin_input_conditioner.sv
// rtl/coin_input_conditioner.sv - synchronise, debounce and encode the coin/reset slide switches
// Emits one registered single-cycle event per accepted one-hot press; multi-hot patterns are rejected.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [4:0] SW,
    output logic       coin_valid,
    output logic [2:0] coin_code,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, FIRE, HOLD, ERROR} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       sync1, sync2, candidate, stable;
    logic [CNT_W-1:0] counter;
    state_t           state, next_state;
    logic [2:0]       enc;
    logic             is_zero, is_multi, is_one_hot;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            stable    <= '0;
            counter   <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                counter   <= '0;
            end else if (counter == CNT_LAST) begin
                stable <= candidate;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

    assign is_zero    = (stable == 5'd0);
    assign is_multi   = ((stable & (stable - 5'd1)) != 5'd0);
    assign is_one_hot = !is_zero && !is_multi;

    always_comb begin
        enc = 3'd0;
        case (stable)
            5'b00001: enc = 3'd0;
            5'b00010: enc = 3'd1;
            5'b00100: enc = 3'd2;
            5'b01000: enc = 3'd3;
            5'b10000: enc = 3'd4;
            default:  enc = 3'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            coin_code <= 3'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == FIRE)
                coin_code <= enc;
        end
    end

    // A switch has to be fully released (stable == 0) before another event can fire.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (is_one_hot)    next_state = FIRE;
                else if (is_multi) next_state = ERROR;
            end
            FIRE:  next_state = HOLD;
            HOLD: begin
                if (is_zero)       next_state = IDLE;
                else if (is_multi) next_state = ERROR;
            end
            ERROR: begin
                if (is_zero)       next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign coin_valid = (state == FIRE);
    assign busy       = (state == FIRE) || (state == HOLD);
    assign error      = (state == ERROR);

endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb/tb_coin_input_conditioner.sv - self-checking bench for coin_input_conditioner
// Reference model: a switch value is debounced once N+1 consecutive edge samples agree.
module tb_coin_input_conditioner;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sw;
    logic       coin_valid;
    logic [2:0] coin_code;
    logic       error;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] hist [0:N+2];
    logic [4:0] m_stable;
    logic       e_valid, e_busy, e_err;
    logic [2:0] e_code;

    coin_input_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .SW         (sw),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] bit_index(input logic [4:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 5; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= N + 2; i++) hist[i] = 5'd0;
        m_stable = 5'd0;
        e_valid  = 1'b0;
        e_busy   = 1'b0;
        e_err    = 1'b0;
        e_code   = 3'd0;
    endtask

    // Drive one sample, advance one edge, update the model, return at the negedge.
    task automatic step(input logic [4:0] v);
        logic [4:0] s;
        logic       agree;
        sw = v;
        @(posedge clk);
        s = m_stable;
        if (e_valid) begin
            e_valid = 1'b0;
            e_busy  = 1'b1;
        end else if (s == 5'd0) begin
            e_busy = 1'b0;
            e_err  = 1'b0;
        end else if ((s & (s - 5'd1)) != 5'd0) begin
            e_busy = 1'b0;
            e_err  = 1'b1;
        end else if (!e_busy && !e_err) begin
            e_valid = 1'b1;
            e_busy  = 1'b1;
            e_code  = bit_index(s);
        end
        for (int i = N + 2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        agree = 1'b1;
        for (int i = 3; i <= N + 2; i++)
            if (hist[i] != hist[2]) agree = 1'b0;
        if (agree) m_stable = hist[2];
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [4:0] v);
        sw  = v;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1;
        sw  = 5'd0;
        model_reset();
        #1;
        n_tests++;
        if ({coin_valid, coin_code, error, busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %b want 000000", {coin_valid, coin_code, error, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(5'd0);
            if (coin_valid) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_idle_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_single_press();
        int pulses = 0, at = -1, busy_at = -1, idle_at = -1;
        logic [2:0] code = 3'd7;
        for (int i = 0; i < 20; i++) begin
            step(5'b00010);
            if (coin_valid) begin
                pulses++;
                if (at < 0) at = i;
                code = coin_code;
            end
            if (busy && busy_at < 0) busy_at = i;
        end
        n_tests++;
        if (at != 7 || pulses != 1 || code != 3'd1) begin
            n_fail++;
            $display("FAIL single_press: at=%0d pulses=%0d code=%0d want 7 1 1", at, pulses, code);
        end
        n_tests++;
        if (busy_at != 7) begin
            n_fail++;
            $display("FAIL single_busy_rise: got %0d want 7", busy_at);
        end
        for (int i = 0; i < 15; i++) begin
            step(5'd0);
            if (!busy && idle_at < 0) idle_at = i;
        end
        n_tests++;
        if (idle_at != 7) begin
            n_fail++;
            $display("FAIL single_busy_fall: got %0d want 7", idle_at);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0, at = -1;
        logic [2:0] code = 3'd7;
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2 == 0) ? 5'b00100 : 5'b00000);
            if (coin_valid) pulses++;
        end
        for (int i = 20; i < 40; i++) begin
            step(5'b00100);
            if (coin_valid) begin
                pulses++;
                if (at < 0) at = i;
                code = coin_code;
            end
        end
        n_tests++;
        if (pulses != 1 || at != 27 || code != 3'd2) begin
            n_fail++;
            $display("FAIL bounce: pulses=%0d at=%0d code=%0d want 1 27 2", pulses, at, code);
        end
        for (int i = 0; i < 12; i++) step(5'd0);
    endtask

    task automatic test_multi_hot();
        int pulses = 0, err_at = -1, clr_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(5'b01001);
            if (coin_valid) pulses++;
            if (error && err_at < 0) err_at = i;
        end
        n_tests++;
        if (err_at != 7 || pulses != 0) begin
            n_fail++;
            $display("FAIL multi_hot: err_at=%0d pulses=%0d want 7 0", err_at, pulses);
        end
        for (int i = 0; i < 12; i++) begin
            step(5'd0);
            if (!error && clr_at < 0) clr_at = i;
        end
        n_tests++;
        if (clr_at != 7) begin
            n_fail++;
            $display("FAIL multi_hot_release: got %0d want 7", clr_at);
        end
    endtask

    task automatic test_no_release();
        int p1 = 0, p2 = 0, p3 = 0, at = -1;
        logic [2:0] c1 = 3'd7, c3 = 3'd7;
        logic       busy_ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(5'b01000);
            if (coin_valid) begin p1++; c1 = coin_code; end
        end
        for (int i = 0; i < 15; i++) begin
            step(5'b00001);
            if (coin_valid) p2++;
            if (!busy) busy_ok = 1'b0;
        end
        for (int i = 0; i < 10; i++) step(5'd0);
        for (int i = 0; i < 15; i++) begin
            step(5'b00001);
            if (coin_valid) begin
                p3++;
                if (at < 0) at = i;
                c3 = coin_code;
            end
        end
        n_tests++;
        if (p1 != 1 || c1 != 3'd3) begin
            n_fail++;
            $display("FAIL no_release_first: pulses=%0d code=%0d want 1 3", p1, c1);
        end
        n_tests++;
        if (p2 != 0 || !busy_ok) begin
            n_fail++;
            $display("FAIL no_release_change: pulses=%0d busy_held=%0d want 0 1", p2, busy_ok);
        end
        n_tests++;
        if (p3 != 1 || at != 7 || c3 != 3'd0) begin
            n_fail++;
            $display("FAIL no_release_second: pulses=%0d at=%0d code=%0d want 1 7 0", p3, at, c3);
        end
        for (int i = 0; i < 12; i++) step(5'd0);
    endtask

    task automatic test_reset_during_pulse();
        int guard = 0;
        while (!coin_valid && guard < 20) begin
            step(5'b00001);
            guard++;
        end
        n_tests++;
        if (!coin_valid) begin
            n_fail++;
            $display("FAIL reset_pulse_setup: got coin_valid=%0d want 1", coin_valid);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({coin_valid, coin_code, error, busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_async_pulse: got %b want 000000", {coin_valid, coin_code, error, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) step(5'd0);
    endtask

    task automatic test_reset_during_hold();
        int p1 = 0, p2 = 0, at = -1;
        logic [2:0] c2 = 3'd7;
        for (int i = 0; i < 12; i++) begin
            step(5'b10000);
            if (coin_valid) p1++;
        end
        n_tests++;
        if (p1 != 1 || coin_code != 3'd4 || !busy) begin
            n_fail++;
            $display("FAIL hold_setup: pulses=%0d code=%0d busy=%0d want 1 4 1", p1, coin_code, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({coin_valid, coin_code, error, busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL hold_reset_clear: got %b want 000000", {coin_valid, coin_code, error, busy});
        end
        apply_reset(5'b10000);
        for (int i = 0; i < 12; i++) begin
            step(5'b10000);
            if (coin_valid) begin
                p2++;
                if (at < 0) at = i;
                c2 = coin_code;
            end
        end
        n_tests++;
        if (p2 != 1 || at != 7 || c2 != 3'd4) begin
            n_fail++;
            $display("FAIL hold_refire: pulses=%0d at=%0d code=%0d want 1 7 4", p2, at, c2);
        end
        for (int i = 0; i < 12; i++) step(5'd0);
    endtask

    task automatic test_random();
        logic [4:0] v = 5'd0;
        int hold = 0;
        int bad  = 0;
        apply_reset(5'd0);
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       v = 5'd0;
                    1, 2:    v = 5'(1 << $urandom_range(0, 4));
                    default: v = 5'($urandom_range(0, 31));
                endcase
                hold = $urandom_range(1, 10);
            end
            hold--;
            step(v);
            n_tests++;
            if ({coin_valid, busy, error} !== {e_valid, e_busy, e_err}) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_flags cycle %0d: got v/b/e=%b want %b", i,
                             {coin_valid, busy, error}, {e_valid, e_busy, e_err});
            end
            n_tests++;
            if (coin_code !== e_code) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_code cycle %0d: got %0d want %0d", i, coin_code, e_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_hot();
        test_no_release();
        test_reset_during_pulse();
        test_reset_during_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
